// File: rtl/uart_rx_engine_pkg.sv
// Shared definitions for the UART receive engine: FSM states, frame sizing
// and the BAUD-select to bit-time decode for a 100 MHz clock.
package uart_rx_engine_pkg;

    localparam int TIMER_W   = 19;
    localparam int IDX_W     = 4;
    localparam int FRAME_MAX = 11;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        DONE
    } rx_state_t;

    // Bit time in clocks; the unused high selects fall back to the fastest rate.
    function automatic logic [TIMER_W-1:0] baud_to_k(input logic [3:0] baud);
        case (baud)
            4'b0000: return 19'd333333;
            4'b0001: return 19'd83333;
            4'b0010: return 19'd41667;
            4'b0011: return 19'd20833;
            4'b0100: return 19'd10417;
            4'b0101: return 19'd5208;
            4'b0110: return 19'd2604;
            4'b0111: return 19'd1736;
            4'b1000: return 19'd868;
            4'b1001: return 19'd434;
            4'b1010: return 19'd217;
            default: return 19'd109;
        endcase
    endfunction

    // Position of the stop bit in the frame (start bit is index 0).
    function automatic logic [IDX_W-1:0] stop_index(input logic eight, input logic pen);
        return eight ? (pen ? 4'd10 : 4'd9) : (pen ? 4'd9 : 4'd8);
    endfunction

endpackage

// File: rtl/uart_rx_engine_if.sv
// Serial line, frame control words and processor read port of the receive engine.
interface uart_rx_engine_if;

    logic       RX;
    logic [3:0] BAUD;
    logic       EIGHT;
    logic       PEN;
    logic       OHEL;
    logic       READ;
    logic [7:0] RX_DATA;
    logic       RXRDY;
    logic       PERR;
    logic       FERR;
    logic       OVF;

    modport master (
        output RX, BAUD, EIGHT, PEN, OHEL, READ,
        input  RX_DATA, RXRDY, PERR, FERR, OVF
    );

    modport slave (
        input  RX, BAUD, EIGHT, PEN, OHEL, READ,
        output RX_DATA, RXRDY, PERR, FERR, OVF
    );

endinterface

// File: rtl/uart_rx_engine_bit_timer.sv
// Loadable bit-time down-counter; expire is high on every clock the count sits at zero.
module uart_rx_engine_bit_timer
    import uart_rx_engine_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic               expire
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: synchronises RX, samples each bit at mid-bit and
// presents the byte plus parity/framing/overflow status to the read port.
module uart_rx_engine
    import uart_rx_engine_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    uart_rx_engine_if.slave  bus
);

    logic                 rx_meta;
    logic                 rxs;
    rx_state_t            state;
    rx_state_t            state_next;
    logic                 timer_load;
    logic [TIMER_W-1:0]   timer_val;
    logic                 expire;
    logic                 sample;
    logic [TIMER_W-1:0]   k_q;
    logic                 eight_q;
    logic                 pen_q;
    logic                 ohel_q;
    logic [IDX_W-1:0]     bit_idx;
    logic [IDX_W-1:0]     stop_idx;
    logic [FRAME_MAX-1:0] frame;
    logic [7:0]           data_word;
    logic                 par_bit;
    logic                 stop_bit;
    logic [7:0]           rx_data;
    logic                 rxrdy;
    logic                 perr;
    logic                 ferr;
    logic                 ovf;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= bus.RX;
            rxs     <= rx_meta;
        end
    end

    // The first load (half bit) uses the live BAUD, since the latch happens on the same edge.
    assign timer_val = (state == IDLE) ? (baud_to_k(bus.BAUD) >> 1) : k_q;

    uart_rx_engine_bit_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .expire   (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        timer_load = 1'b0;
        sample     = 1'b0;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    timer_load = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (expire) begin
                    if (rxs) begin
                        state_next = IDLE;
                    end else begin
                        timer_load = 1'b1;
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (expire) begin
                    timer_load = 1'b1;
                    sample     = 1'b1;
                    if (bit_idx == stop_idx) begin
                        state_next = DONE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Frame configuration is frozen at the start edge so mid-frame changes wait a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q     <= '0;
            eight_q <= 1'b0;
            pen_q   <= 1'b0;
            ohel_q  <= 1'b0;
            bit_idx <= '0;
            frame   <= '0;
        end else begin
            if (state == IDLE && !rxs) begin
                k_q     <= baud_to_k(bus.BAUD);
                eight_q <= bus.EIGHT;
                pen_q   <= bus.PEN;
                ohel_q  <= bus.OHEL;
            end
            if (state == START && expire && !rxs) begin
                bit_idx <= 4'd1;
            end
            if (sample) begin
                frame[bit_idx] <= rxs;
                bit_idx        <= bit_idx + 1'b1;
            end
        end
    end

    assign stop_idx  = stop_index(eight_q, pen_q);
    assign data_word = eight_q ? frame[8:1] : {1'b0, frame[7:1]};
    assign par_bit   = eight_q ? frame[9] : frame[8];
    assign stop_bit  = frame[stop_idx];

    // A completing frame takes priority over a READ arriving on the same clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data <= '0;
            rxrdy   <= 1'b0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            ovf     <= 1'b0;
        end else if (state == DONE) begin
            rx_data <= data_word;
            perr    <= pen_q & ((^data_word ^ par_bit) != ohel_q);
            ferr    <= ~stop_bit;
            ovf     <= rxrdy & ~bus.READ;
            rxrdy   <= 1'b1;
        end else if (bus.READ && rxrdy) begin
            rxrdy <= 1'b0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
            ovf   <= 1'b0;
        end
    end

    assign bus.RX_DATA = rx_data;
    assign bus.RXRDY   = rxrdy;
    assign bus.PERR    = perr;
    assign bus.FERR    = ferr;
    assign bus.OVF     = ovf;

endmodule
